multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have ports: clk  input  1  single clock, all state on rising edge.
REQ-002 SHALL have: rst  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have: Opcode  input  6  instruction[31:26] from the instruction register.
REQ-004 SHALL have: Zero, OverFlow  input  1 each  ALU flags of the current cycle.
REQ-005 SHALL have: mem_ready  input  1  memory-completion handshake, sampled in memory states.
REQ-006 SHALL have outputs, 1 bit each: PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, ALUSrcA, RegWrite, RegDst, EPCWrite, CauseWrite, IntCause.
REQ-007 SHALL have outputs, 2 bits each: PCSource, ALUOp, ALUSrcB.
REQ-008 SHALL have: state  output  4  current FSM state, for debug.

Function
REQ-009 SHALL be a Moore FSM: outputs depend only on state, except PCWrite and RegWrite qualifiers stated below.
REQ-010 SHALL implement states:
- FETCH=0, DECODE=1, MEMADDR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXEC=6, RCOMPLETE=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11, EXCEPT=12.
REQ-011 In FETCH, the block SHALL drive:
- MemRead=1, IorD=0, IRWrite=1, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
- PCWrite=mem_ready.
- It SHALL stay in FETCH until mem_ready=1.
REQ-012 In DECODE, the block SHALL drive ALUSrcA=0, ALUSrcB=11, ALUOp=00, then branch on Opcode:
- 000000 -> EXEC.
- 100011 and 101011 -> MEMADDR.
- 000100 -> BRANCH.
- 000010 -> JUMP.
- 001000 -> ADDIEX.
- any other opcode -> EXCEPT with IntCause=0.
REQ-013 MEMADDR SHALL drive ALUSrcA=1, ALUSrcB=10, ALUOp=00, then go to MEMREAD for lw or MEMWRITE for sw.
REQ-014 MEMREAD SHALL drive MemRead=1, IorD=1, holding until mem_ready=1, then go to MEMWB.
REQ-015 MEMWB SHALL drive RegWrite=1, MemtoReg=1, RegDst=0, then go to FETCH.
REQ-016 MEMWRITE SHALL drive MemWrite=1, IorD=1, holding until mem_ready=1, then go to FETCH.
REQ-017 EXEC SHALL drive ALUSrcA=1, ALUSrcB=00, ALUOp=10, then go to RCOMPLETE.
REQ-018 RCOMPLETE SHALL drive RegDst=1, MemtoReg=0, with RegWrite=~OverFlow:
- OverFlow=1 -> EXCEPT with IntCause=1.
- otherwise -> FETCH.
REQ-019 BRANCH SHALL drive ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01, then go to FETCH.
REQ-020 JUMP SHALL drive PCWrite=1, PCSource=10, then go to FETCH.
REQ-021 ADDIEX SHALL drive ALUSrcA=1, ALUSrcB=10, ALUOp=00, then go to ADDIWB.
REQ-022 ADDIWB SHALL drive RegDst=0, MemtoReg=0, with RegWrite=~OverFlow; OverFlow=1 -> EXCEPT with IntCause=1, otherwise -> FETCH.
REQ-023 EXCEPT SHALL drive EPCWrite=1, CauseWrite=1, ALUSrcA=0, ALUSrcB=01, ALUOp=01 (EPC=PC-4), PCWrite=1, PCSource=11 (vector 0x8000_0180), then go to FETCH.
REQ-024 IntCause SHALL be a register:
- loaded only on entry to EXCEPT;
- held at all other times.
REQ-025 Every control output not listed for a state SHALL be 0.
REQ-026 Only one of MemRead and MemWrite SHALL ever be 1 in a given cycle.
REQ-027 Unused state encodings 13-15 SHALL go to FETCH on the next edge with all outputs 0.
REQ-028 Cycle counts with mem_ready tied high SHALL be:
- R-type 4; lw 5; sw 4; beq 3; j 3; addi 4; undefined opcode 3.
REQ-029 Each cycle mem_ready=0 in FETCH, MEMREAD or MEMWRITE SHALL add exactly one cycle.

Reset
REQ-030 When rst=0, state SHALL asynchronously become FETCH and IntCause SHALL become 0.
REQ-031 All outputs other than FETCH's Moore outputs SHALL be 0 while rst=0, with PCWrite=0 and IRWrite=0.
REQ-032 Reset asserted mid-instruction SHALL abort it: no register write or memory write occurs after the asserting edge.
REQ-033 After rst deasserts, the first active edge SHALL execute FETCH.

Structure
REQ-034 A shared package SHALL hold:
- state encodings;
- opcode constants (RTYPE, LW, SW, BEQ, J, ADDI);
- ALUOp codes;
- PCSource codes;
- the exception vector constant.
REQ-035 One sub-module, mc_output_decode, SHALL be combinational and map state (plus OverFlow and mem_ready) to the control outputs; the top SHALL hold only the state and IntCause registers and the next-state logic.

Verification
REQ-036 lw with mem_ready=1: the bench SHALL see states 0,1,2,3,4,0, with RegWrite=1 and MemtoReg=1 in cycle 5 only.
REQ-037 lw with mem_ready low for 2 cycles in MEMREAD: state 3 SHALL persist 3 cycles, and MemRead SHALL be 1 throughout.
REQ-038 beq with Zero=1: states SHALL be 0,1,8,0, with PCWriteCond=1 and PCSource=01 in BRANCH.
REQ-039 R-type with OverFlow=1 in RCOMPLETE: RegWrite SHALL be 0, then EXCEPT follows with IntCause=1, EPCWrite=1 and PCSource=11.
REQ-040 Opcode=111111: states SHALL be 0,1,12,0, with IntCause=0.
REQ-041 rst=0 mid-MEMWRITE: state SHALL read 0 immediately (before the next edge), and MemWrite SHALL be 0.

Source files
------------

// File: rtl/multicycle_control_pkg.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control_pkg
// Description : Shared encodings for the multicycle MIPS control unit.
//               Contents: FSM state codes, opcodes, ALU/PC mux selects,
//               exception vector and the control-word struct.
// Revision    : 1.0 - initial release
// ============================================================================
package multicycle_control_pkg;

    // FSM state encodings (4-bit; codes 13-15 are unused)
    localparam logic [3:0] FETCH     = 4'd0;
    localparam logic [3:0] DECODE    = 4'd1;
    localparam logic [3:0] MEMADDR   = 4'd2;
    localparam logic [3:0] MEMREAD   = 4'd3;
    localparam logic [3:0] MEMWB     = 4'd4;
    localparam logic [3:0] MEMWRITE  = 4'd5;
    localparam logic [3:0] EXEC      = 4'd6;
    localparam logic [3:0] RCOMPLETE = 4'd7;
    localparam logic [3:0] BRANCH    = 4'd8;
    localparam logic [3:0] JUMP      = 4'd9;
    localparam logic [3:0] ADDIEX    = 4'd10;
    localparam logic [3:0] ADDIWB    = 4'd11;
    localparam logic [3:0] EXCEPT    = 4'd12;

    // Instruction opcodes (instruction[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    // ALUOp codes
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // PCSource codes
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_EXC    = 2'b11;

    // ALUSrcB codes
    localparam logic [1:0] SRCB_REG      = 2'b00;
    localparam logic [1:0] SRCB_FOUR     = 2'b01;
    localparam logic [1:0] SRCB_IMM      = 2'b10;
    localparam logic [1:0] SRCB_IMM_SHL2 = 2'b11;

    // Exception cause codes held in the IntCause register
    localparam logic CAUSE_UNDEF = 1'b0;
    localparam logic CAUSE_OVF   = 1'b1;

    // Address the datapath loads into PC when PCSource selects the exception input
    localparam logic [31:0] EXC_VECTOR = 32'h8000_0180;

    // Per-state control word produced by the output decoder
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic       reg_write;
        logic       reg_dst;
        logic       epc_write;
        logic       cause_write;
        logic [1:0] pc_source;
        logic [1:0] alu_op;
        logic [1:0] alu_src_b;
    } ctrl_t;

endpackage : multicycle_control_pkg
`default_nettype wire

// File: rtl/mc_output_decode.sv
`default_nettype none
// ============================================================================
// Module      : mc_output_decode
// Description : Combinational state-to-control-word decoder. Pure Moore
//               outputs, except PCWrite in FETCH (mem_ready) and RegWrite
//               in the ALU write-back states (suppressed on overflow).
// Revision    : 1.0 - initial release
// ============================================================================
module mc_output_decode
    import multicycle_control_pkg::*;
(
    input  logic [3:0] state,
    input  logic       over_flow,
    input  logic       mem_ready,
    output ctrl_t      ctrl
);

    // Decode the current state into the datapath control word
    always_comb begin
        ctrl = '0;
        case (state)
            FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.ir_write  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.pc_source = PCSRC_ALU;
                // PC+4 is committed only when the instruction word arrives
                ctrl.pc_write  = mem_ready;
            end
            DECODE: begin
                ctrl.alu_src_b = SRCB_IMM_SHL2;
                ctrl.alu_op    = ALUOP_ADD;
            end
            MEMADDR, ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            MEMREAD: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
            end
            MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            MEMWRITE: begin
                ctrl.mem_write = 1'b1;
                ctrl.iord      = 1'b1;
            end
            EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REG;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            RCOMPLETE: begin
                ctrl.reg_dst   = 1'b1;
                ctrl.reg_write = ~over_flow;
            end
            BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_REG;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
            end
            JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
            end
            ADDIWB: begin
                ctrl.reg_write = ~over_flow;
            end
            EXCEPT: begin
                // ALU computes PC-4 for EPC while PC jumps to the vector
                ctrl.epc_write   = 1'b1;
                ctrl.cause_write = 1'b1;
                ctrl.alu_src_b   = SRCB_FOUR;
                ctrl.alu_op      = ALUOP_SUB;
                ctrl.pc_write    = 1'b1;
                ctrl.pc_source   = PCSRC_EXC;
            end
            default: ctrl = '0;
        endcase
    end

endmodule : mc_output_decode
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control
// Description : Multicycle MIPS control FSM. Holds the state and IntCause
//               registers and the next-state logic; control outputs come
//               from mc_output_decode.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control
    import multicycle_control_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] Opcode,
    input  logic       Zero,
    input  logic       OverFlow,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       ALUSrcA,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       EPCWrite,
    output logic       CauseWrite,
    output logic       IntCause,
    output logic [1:0] PCSource,
    output logic [1:0] ALUOp,
    output logic [1:0] ALUSrcB,
    output logic [3:0] state
);

    logic [3:0] next_state;
    logic       load_cause;
    logic       cause_value;
    ctrl_t      ctrl;

    // Zero is consumed by the datapath together with PCWriteCond
    logic unused_zero;
    assign unused_zero = Zero;

    // Next-state selection and IntCause load on every transition into EXCEPT
    always_comb begin
        next_state  = FETCH;
        load_cause  = 1'b0;
        cause_value = CAUSE_UNDEF;
        case (state)
            FETCH:    next_state = mem_ready ? DECODE : FETCH;
            DECODE: begin
                case (Opcode)
                    OP_RTYPE:     next_state = EXEC;
                    OP_LW, OP_SW: next_state = MEMADDR;
                    OP_BEQ:       next_state = BRANCH;
                    OP_J:         next_state = JUMP;
                    OP_ADDI:      next_state = ADDIEX;
                    default: begin
                        next_state  = EXCEPT;
                        load_cause  = 1'b1;
                        cause_value = CAUSE_UNDEF;
                    end
                endcase
            end
            MEMADDR:  next_state = (Opcode == OP_SW) ? MEMWRITE : MEMREAD;
            MEMREAD:  next_state = mem_ready ? MEMWB : MEMREAD;
            MEMWB:    next_state = FETCH;
            MEMWRITE: next_state = mem_ready ? FETCH : MEMWRITE;
            EXEC:     next_state = RCOMPLETE;
            ADDIEX:   next_state = ADDIWB;
            RCOMPLETE, ADDIWB: begin
                if (OverFlow) begin
                    next_state  = EXCEPT;
                    load_cause  = 1'b1;
                    cause_value = CAUSE_OVF;
                end else begin
                    next_state = FETCH;
                end
            end
            BRANCH:   next_state = FETCH;
            JUMP:     next_state = FETCH;
            EXCEPT:   next_state = FETCH;
            default:  next_state = FETCH;   // unused codes 13-15 recover
        endcase
    end

    // State register; reset lands in FETCH immediately
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= FETCH;
        end else begin
            state <= next_state;
        end
    end

    // IntCause register, written only when entering EXCEPT
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            IntCause <= CAUSE_UNDEF;
        end else if (load_cause) begin
            IntCause <= cause_value;
        end
    end

    mc_output_decode u_decode (
        .state     (state),
        .over_flow (OverFlow),
        .mem_ready (mem_ready),
        .ctrl      (ctrl)
    );

    // While reset is held, FETCH must not commit the PC or the instruction register
    assign PCWrite     = ctrl.pc_write & rst;
    assign IRWrite     = ctrl.ir_write & rst;
    assign PCWriteCond = ctrl.pc_write_cond;
    assign IorD        = ctrl.iord;
    assign MemRead     = ctrl.mem_read;
    assign MemWrite    = ctrl.mem_write;
    assign MemtoReg    = ctrl.mem_to_reg;
    assign ALUSrcA     = ctrl.alu_src_a;
    assign RegWrite    = ctrl.reg_write;
    assign RegDst      = ctrl.reg_dst;
    assign EPCWrite    = ctrl.epc_write;
    assign CauseWrite  = ctrl.cause_write;
    assign PCSource    = ctrl.pc_source;
    assign ALUOp       = ctrl.alu_op;
    assign ALUSrcB     = ctrl.alu_src_b;

endmodule : multicycle_control
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_control
// Description : Directed self-checking bench for multicycle_control.
//               Walks each instruction class cycle by cycle and compares
//               state and the full control word against hand-derived values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] Opcode;
    logic       Zero, OverFlow, mem_ready;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, ALUSrcA, RegWrite, RegDst, EPCWrite, CauseWrite;
    logic       IntCause;
    logic [1:0] PCSource, ALUOp, ALUSrcB;
    logic [3:0] state;

    int errors = 0;
    int checks = 0;

    // Observed control word, bit order matches expect_ctrl below
    logic [18:0] ctrl_vec;
    assign ctrl_vec = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                       MemtoReg, ALUSrcA, RegWrite, RegDst, EPCWrite, CauseWrite,
                       IntCause, PCSource, ALUOp, ALUSrcB};

    multicycle_control dut (
        .clk         (clk),
        .rst         (rst),
        .Opcode      (Opcode),
        .Zero        (Zero),
        .OverFlow    (OverFlow),
        .mem_ready   (mem_ready),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .IorD        (IorD),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .IRWrite     (IRWrite),
        .MemtoReg    (MemtoReg),
        .ALUSrcA     (ALUSrcA),
        .RegWrite    (RegWrite),
        .RegDst      (RegDst),
        .EPCWrite    (EPCWrite),
        .CauseWrite  (CauseWrite),
        .IntCause    (IntCause),
        .PCSource    (PCSource),
        .ALUOp       (ALUOp),
        .ALUSrcB     (ALUSrcB),
        .state       (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Expected control word per state, written out from the state table.
    // Bits: 18 PCWrite 17 PCWriteCond 16 IorD 15 MemRead 14 MemWrite 13 IRWrite
    // 12 MemtoReg 11 ALUSrcA 10 RegWrite 9 RegDst 8 EPCWrite 7 CauseWrite
    // 6 IntCause 5:4 PCSource 3:2 ALUOp 1:0 ALUSrcB
    function automatic logic [18:0] expect_ctrl(input logic [3:0] st, input logic mr,
                                                input logic ovf, input logic ic);
        logic [18:0] e;
        e    = '0;
        e[6] = ic;
        case (st)
            4'd0:  begin e[18] = mr; e[15] = 1'b1; e[13] = 1'b1; e[1:0] = 2'b01; end
            4'd1:  begin e[1:0] = 2'b11; end
            4'd2:  begin e[11] = 1'b1; e[1:0] = 2'b10; end
            4'd3:  begin e[16] = 1'b1; e[15] = 1'b1; end
            4'd4:  begin e[10] = 1'b1; e[12] = 1'b1; end
            4'd5:  begin e[16] = 1'b1; e[14] = 1'b1; end
            4'd6:  begin e[11] = 1'b1; e[3:2] = 2'b10; end
            4'd7:  begin e[9] = 1'b1; e[10] = ~ovf; end
            4'd8:  begin e[11] = 1'b1; e[3:2] = 2'b01; e[17] = 1'b1; e[5:4] = 2'b01; end
            4'd9:  begin e[18] = 1'b1; e[5:4] = 2'b10; end
            4'd10: begin e[11] = 1'b1; e[1:0] = 2'b10; end
            4'd11: begin e[10] = ~ovf; end
            4'd12: begin e[8] = 1'b1; e[7] = 1'b1; e[1:0] = 2'b01; e[3:2] = 2'b01;
                         e[18] = 1'b1; e[5:4] = 2'b11; end
            default: e = {12'd0, ic, 6'd0};
        endcase
        return e;
    endfunction

    // One clock cycle: apply inputs, check state and control word, advance
    task automatic cyc(input string tag, input logic [3:0] es, input logic mr,
                       input logic ovf, input logic ic);
        mem_ready = mr;
        OverFlow  = ovf;
        #1;
        check({tag, ".state"}, {28'd0, state}, {28'd0, es});
        check({tag, ".ctrl"}, {13'd0, ctrl_vec}, {13'd0, expect_ctrl(es, mr, ovf, ic)});
        @(posedge clk);
        #1;
    endtask

    logic [18:0] rst_vec;

    initial begin
        rst       = 1'b0;
        Opcode    = 6'b000000;
        Zero      = 1'b0;
        OverFlow  = 1'b0;
        mem_ready = 1'b1;
        // FETCH outputs with PCWrite and IRWrite held off during reset
        rst_vec     = expect_ctrl(4'd0, 1'b1, 1'b0, 1'b0);
        rst_vec[18] = 1'b0;
        rst_vec[13] = 1'b0;

        #2;
        check("reset.state", {28'd0, state}, 32'd0);
        check("reset.ctrl", {13'd0, ctrl_vec}, {13'd0, rst_vec});
        @(posedge clk); #1;
        check("reset_edge.state", {28'd0, state}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;

        // lw, memory always ready: 0,1,2,3,4
        Opcode = 6'b100011;
        cyc("lw0", 4'd0, 1'b1, 1'b0, 1'b0);
        cyc("lw1", 4'd1, 1'b1, 1'b0, 1'b0);
        cyc("lw2", 4'd2, 1'b1, 1'b0, 1'b0);
        cyc("lw3", 4'd3, 1'b1, 1'b0, 1'b0);
        cyc("lw4", 4'd4, 1'b1, 1'b0, 1'b0);

        // lw with two wait cycles in MEMREAD
        cyc("lwW0", 4'd0, 1'b1, 1'b0, 1'b0);
        cyc("lwW1", 4'd1, 1'b1, 1'b0, 1'b0);
        cyc("lwW2", 4'd2, 1'b1, 1'b0, 1'b0);
        cyc("lwW3a", 4'd3, 1'b0, 1'b0, 1'b0);
        cyc("lwW3b", 4'd3, 1'b0, 1'b0, 1'b0);
        cyc("lwW3c", 4'd3, 1'b1, 1'b0, 1'b0);
        cyc("lwW4", 4'd4, 1'b1, 1'b0, 1'b0);

        // sw with a wait in FETCH and one in MEMWRITE
        Opcode = 6'b101011;
        cyc("swF0a", 4'd0, 1'b0, 1'b0, 1'b0);
        cyc("swF0b", 4'd0, 1'b1, 1'b0, 1'b0);
        cyc("sw1", 4'd1, 1'b1, 1'b0, 1'b0);
        cyc("sw2", 4'd2, 1'b1, 1'b0, 1'b0);
        cyc("sw5a", 4'd5, 1'b0, 1'b0, 1'b0);
        cyc("sw5b", 4'd5, 1'b1, 1'b0, 1'b0);

        // beq taken: 0,1,8
        Opcode = 6'b000100;
        Zero   = 1'b1;
        cyc("beq0", 4'd0, 1'b1, 1'b0, 1'b0);
        cyc("beq1", 4'd1, 1'b1, 1'b0, 1'b0);
        cyc("beq8", 4'd8, 1'b1, 1'b0, 1'b0);
        Zero   = 1'b0;

        // j: 0,1,9
        Opcode = 6'b000010;
        cyc("j0", 4'd0, 1'b1, 1'b0, 1'b0);
        cyc("j1", 4'd1, 1'b1, 1'b0, 1'b0);
        cyc("j9", 4'd9, 1'b1, 1'b0, 1'b0);

        // addi, no overflow: 0,1,10,11
        Opcode = 6'b001000;
        cyc("addi0", 4'd0, 1'b1, 1'b0, 1'b0);
        cyc("addi1", 4'd1, 1'b1, 1'b0, 1'b0);
        cyc("addi10", 4'd10, 1'b1, 1'b0, 1'b0);
        cyc("addi11", 4'd11, 1'b1, 1'b0, 1'b0);

        // R-type with overflow: write suppressed, EXCEPT with cause 1
        Opcode = 6'b000000;
        cyc("rovf0", 4'd0, 1'b1, 1'b0, 1'b0);
        cyc("rovf1", 4'd1, 1'b1, 1'b0, 1'b0);
        cyc("rovf6", 4'd6, 1'b1, 1'b0, 1'b0);
        cyc("rovf7", 4'd7, 1'b1, 1'b1, 1'b0);
        cyc("rovf12", 4'd12, 1'b1, 1'b0, 1'b1);

        // R-type without overflow: IntCause holds 1 throughout
        cyc("r0", 4'd0, 1'b1, 1'b0, 1'b1);
        cyc("r1", 4'd1, 1'b1, 1'b0, 1'b1);
        cyc("r6", 4'd6, 1'b1, 1'b0, 1'b1);
        cyc("r7", 4'd7, 1'b1, 1'b0, 1'b1);

        // Undefined opcode: 0,1,12 with cause reloaded to 0
        Opcode = 6'b111111;
        cyc("undef0", 4'd0, 1'b1, 1'b0, 1'b1);
        cyc("undef1", 4'd1, 1'b1, 1'b0, 1'b1);
        cyc("undef12", 4'd12, 1'b1, 1'b0, 1'b0);

        // addi with overflow -> EXCEPT, cause 1
        Opcode = 6'b001000;
        cyc("aovf0", 4'd0, 1'b1, 1'b0, 1'b0);
        cyc("aovf1", 4'd1, 1'b1, 1'b0, 1'b0);
        cyc("aovf10", 4'd10, 1'b1, 1'b0, 1'b0);
        cyc("aovf11", 4'd11, 1'b1, 1'b1, 1'b0);
        cyc("aovf12", 4'd12, 1'b1, 1'b0, 1'b1);

        // sw aborted by reset while waiting in MEMWRITE
        Opcode = 6'b101011;
        cyc("swr0", 4'd0, 1'b1, 1'b0, 1'b1);
        cyc("swr1", 4'd1, 1'b1, 1'b0, 1'b1);
        cyc("swr2", 4'd2, 1'b1, 1'b0, 1'b1);
        mem_ready = 1'b0;
        #1;
        check("swr5.state", {28'd0, state}, 32'd5);
        check("swr5.memwrite", {31'd0, MemWrite}, 32'd1);
        rst = 1'b0;
        #1;
        check("abort.state", {28'd0, state}, 32'd0);
        check("abort.memwrite", {31'd0, MemWrite}, 32'd0);
        check("abort.ctrl", {13'd0, ctrl_vec}, {13'd0, rst_vec});
        @(posedge clk); #1;
        check("abort_edge.state", {28'd0, state}, 32'd0);
        rst = 1'b1;
        cyc("post0", 4'd0, 1'b1, 1'b0, 1'b0);
        cyc("post1", 4'd1, 1'b1, 1'b0, 1'b0);
        cyc("post2", 4'd2, 1'b1, 1'b0, 1'b0);
        cyc("post5", 4'd5, 1'b1, 1'b0, 1'b0);
        cyc("post_end", 4'd0, 1'b1, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_multicycle_control
`default_nettype wire
